// File: rtl/csr_file_m.sv
// Machine-mode CSR file: trap/mret sequencing, interrupt arbitration,
// 64-bit cycle/instret counters and a one-cycle settle after mstatus/mie writes.
module csr_file_m #(
    parameter int              XLEN      = 32,
    parameter int              CNT_W     = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100,
    parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      cmd,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            illegal,
    input  logic            exception,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            retire,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            irq_timer,
    output logic            trap_taken,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] epc_out,
    output logic            csr_stall,
    output logic            mstatus_mie
);

    localparam int HI_W = CNT_W - XLEN;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
    localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(2'b11);

    typedef enum logic [1:0] {CMD_NONE, CMD_WRITE, CMD_SET, CMD_CLEAR} cmd_t;
    typedef enum logic {IDLE, SETTLE} state_t;

    state_t state, state_n;

    logic              mie_bit, mpie;
    logic [XLEN-1:0]   mie_r, mtvec, mscratch, mepc, mcause, mtval;
    logic [2:0]        mip;                 // {MEIP, MTIP, MSIP}
    logic [CNT_W-1:0]  mcycle, minstret, mcycle_n, minstret_n;

    logic [XLEN-1:0]   rd, wval, cause_word, vec_off;
    logic              impl, ro, writes, csr_we;
    logic [2:0]        irq_vec;
    logic              irq_take, exc_take, trap, trap_is_irq, mret_take;
    logic [3:0]        irq_cause, cause;

    // Read mux; also classifies the address as implemented / read-only.
    always_comb begin
        rd   = '0;
        impl = 1'b1;
        ro   = 1'b0;
        case (addr)
            A_MSTATUS: begin
                rd[3]     = mie_bit;
                rd[7]     = mpie;
                rd[12:11] = 2'b11;
            end
            A_MISA:      begin rd = MISA_VAL; ro = 1'b1; end
            A_MIE:       rd = mie_r;
            A_MTVEC:     rd = mtvec;
            A_MSCRATCH:  rd = mscratch;
            A_MEPC:      rd = mepc;
            A_MCAUSE:    rd = mcause;
            A_MTVAL:     rd = mtval;
            A_MIP: begin
                rd[11] = mip[2];
                rd[7]  = mip[1];
                rd[3]  = mip[0];
                ro     = 1'b1;
            end
            A_MCYCLE:    rd = mcycle[XLEN-1:0];
            A_MINSTRET:  rd = minstret[XLEN-1:0];
            A_MCYCLEH:   rd[HI_W-1:0] = mcycle[CNT_W-1:XLEN];
            A_MINSTRETH: rd[HI_W-1:0] = minstret[CNT_W-1:XLEN];
            A_MHARTID:   ro = 1'b1;
            default:     impl = 1'b0;
        endcase
    end

    assign rdata = rd;

    always_comb begin
        wval = rd;
        case (cmd)
            CMD_WRITE: wval = wdata;
            CMD_SET:   wval = rd | wdata;
            CMD_CLEAR: wval = rd & ~wdata;
            default:   wval = rd;
        endcase
    end

    assign writes  = (cmd == CMD_WRITE) ||
                     (((cmd == CMD_SET) || (cmd == CMD_CLEAR)) && (wdata != '0));
    assign illegal = ((cmd != CMD_NONE) && !impl) || (writes && ro);

    assign irq_vec  = mip & {mie_r[11], mie_r[7], mie_r[3]};
    assign irq_take = mie_bit && (irq_vec != 3'b000) && (state == IDLE);

    always_comb begin
        irq_cause = 4'd7;
        if (irq_vec[2])      irq_cause = 4'd11;
        else if (irq_vec[0]) irq_cause = 4'd3;
    end

    // Exceptions win over everything; masking with rst_n keeps trap_taken low in reset.
    assign exc_take    = exception && rst_n;
    assign trap        = exc_take || irq_take;
    assign trap_is_irq = !exc_take && irq_take;
    assign cause       = exc_take ? exc_cause : irq_cause;
    assign mret_take   = mret && !trap;
    assign csr_we      = writes && impl && !ro && !trap && !mret_take;

    always_comb begin
        cause_word             = '0;
        cause_word[XLEN-1]     = trap_is_irq;
        cause_word[3:0]        = cause;
        vec_off                = '0;
        if (trap_is_irq && (mtvec[1:0] == 2'b01))
            vec_off[5:2] = irq_cause;
    end

    assign trap_vector = {mtvec[XLEN-1:2], 2'b00} + vec_off;
    assign trap_taken  = trap;
    assign epc_out     = mepc;
    assign mstatus_mie = mie_bit;

    // A write to one counter half replaces this cycle's increment; the other half holds.
    always_comb begin
        mcycle_n   = mcycle + CNT_W'(1);
        minstret_n = minstret + CNT_W'(retire && !trap);
        if (csr_we) begin
            case (addr)
                A_MCYCLE:    mcycle_n   = {mcycle[CNT_W-1:XLEN], wval};
                A_MCYCLEH:   mcycle_n   = {wval[HI_W-1:0], mcycle[XLEN-1:0]};
                A_MINSTRET:  minstret_n = {minstret[CNT_W-1:XLEN], wval};
                A_MINSTRETH: minstret_n = {wval[HI_W-1:0], minstret[XLEN-1:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_bit  <= 1'b0;
            mpie     <= 1'b0;
            mie_r    <= '0;
            mip      <= '0;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mip      <= {irq_ext, irq_timer, irq_sw};
            mcycle   <= mcycle_n;
            minstret <= minstret_n;
            if (trap) begin
                mepc    <= exc_pc & EPC_MASK;
                mcause  <= cause_word;
                mtval   <= exc_take ? exc_tval : '0;
                mpie    <= mie_bit;
                mie_bit <= 1'b0;
            end else if (mret_take) begin
                mie_bit <= mpie;
                mpie    <= 1'b1;
            end else if (csr_we) begin
                case (addr)
                    A_MSTATUS: begin
                        mie_bit <= wval[3];
                        mpie    <= wval[7];
                    end
                    A_MIE:      mie_r    <= wval & MIE_MASK;
                    A_MTVEC:    mtvec    <= {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
                    A_MSCRATCH: mscratch <= wval;
                    A_MEPC:     mepc     <= wval & EPC_MASK;
                    A_MCAUSE:   mcause   <= wval;
                    A_MTVAL:    mtval    <= wval;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        csr_stall = 1'b0;
        case (state)
            IDLE:
                if (csr_we && ((addr == A_MSTATUS) || (addr == A_MIE)))
                    state_n = SETTLE;
            SETTLE: begin
                csr_stall = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m: table of CSR accesses plus hand-written
// trap, mret, counter and reset-during-settle sequences.
module tb_csr_file_m;

    logic        clk, rst_n;
    logic [1:0]  cmd;
    logic [11:0] addr;
    logic [31:0] wdata, rdata, exc_pc, exc_tval, trap_vector, epc_out;
    logic        illegal, exception, mret, retire;
    logic [3:0]  exc_cause;
    logic        irq_ext, irq_sw, irq_timer;
    logic        trap_taken, csr_stall, mstatus_mie;

    int unsigned pass_cnt = 0;
    int unsigned total    = 0;

    localparam logic [1:0] NONE = 2'd0, WR = 2'd1, SET = 2'd2, CLR = 2'd3;

    csr_file_m #(
        .XLEN     (32),
        .CNT_W    (64),
        .MTVEC_RST(32'h0000_0100),
        .MISA_VAL (32'h4000_0100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .illegal    (illegal),
        .exception  (exception),
        .exc_cause  (exc_cause),
        .exc_pc     (exc_pc),
        .exc_tval   (exc_tval),
        .mret       (mret),
        .retire     (retire),
        .irq_ext    (irq_ext),
        .irq_sw     (irq_sw),
        .irq_timer  (irq_timer),
        .trap_taken (trap_taken),
        .trap_vector(trap_vector),
        .epc_out    (epc_out),
        .csr_stall  (csr_stall),
        .mstatus_mie(mstatus_mie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [11:0] a, input logic [31:0] d);
        cmd   = c;
        addr  = a;
        wdata = d;
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        ill;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{WR,  12'h340, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{SET, 12'h340, 32'h0000_0010, 1'b0, 32'hDEAD_BEFF};
        vecs[2]  = '{CLR, 12'h340, 32'hFFFF_0000, 1'b0, 32'h0000_BEFF};
        vecs[3]  = '{SET, 12'h340, 32'h0000_0000, 1'b0, 32'h0000_BEFF};
        vecs[4]  = '{WR,  12'h341, 32'h1234_5677, 1'b0, 32'h1234_5674};
        vecs[5]  = '{WR,  12'h305, 32'h0000_0203, 1'b0, 32'h0000_0200};
        vecs[6]  = '{WR,  12'h305, 32'h0000_0101, 1'b0, 32'h0000_0101};
        vecs[7]  = '{WR,  12'h304, 32'hFFFF_FFFF, 1'b0, 32'h0000_0888};
        vecs[8]  = '{WR,  12'h304, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[9]  = '{WR,  12'hF14, 32'h0000_0005, 1'b1, 32'h0000_0000};
        vecs[10] = '{SET, 12'h7C0, 32'h0000_0001, 1'b1, 32'h0000_0000};
        vecs[11] = '{SET, 12'hF14, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[12] = '{WR,  12'h301, 32'h0000_0000, 1'b1, 32'h4000_0100};
        vecs[13] = '{WR,  12'h343, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
        vecs[14] = '{WR,  12'h342, 32'h8000_000B, 1'b0, 32'h8000_000B};
        vecs[15] = '{CLR, 12'h344, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[16] = '{NONE,12'h123, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[17] = '{WR,  12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_1888};
        vecs[18] = '{CLR, 12'h300, 32'h0000_0088, 1'b0, 32'h0000_1800};

        rst_n = 1'b0;
        drive(NONE, 12'h305, '0);
        exception = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        mret = 1'b0; retire = 1'b0;
        irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;

        // Reset state
        step(); step();
        chk1("rst_trap_taken", trap_taken, 1'b0);
        chk1("rst_csr_stall", csr_stall, 1'b0);
        chk1("rst_mstatus_mie", mstatus_mie, 1'b0);
        chk1("rst_illegal", illegal, 1'b0);
        chk("rst_epc_out", epc_out, 32'h0);
        chk("rst_trap_vector", trap_vector, 32'h100);
        peek("rst_mtvec", 12'h305, 32'h100);
        peek("rst_mstatus", 12'h300, 32'h1800);
        peek("rst_mcycle", 12'hB00, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int unsigned i = 0; i < 19; i++) begin
            drive(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            #1;
            chk1($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
            step();
            cmd = NONE;
            #1;
            chk($sformatf("vec%0d_readback", i), rdata, vecs[i].rd);
        end

        // SET MIE -> settle cycle
        step();
        drive(SET, 12'h300, 32'h8);
        #1;
        chk1("A_stall_before", csr_stall, 1'b0);
        step();
        cmd = NONE;
        #1;
        chk("A_mstatus", rdata, 32'h1808);
        chk1("A_stall", csr_stall, 1'b1);
        chk1("A_mie_out", mstatus_mie, 1'b1);
        step();
        chk1("A_stall_cleared", csr_stall, 1'b0);

        // Timer interrupt, blocked during SETTLE, vectored mtvec, CSR write dropped
        drive(WR, 12'h304, 32'h80);
        irq_timer = 1'b1;
        #1;
        chk1("B_no_trap_c1", trap_taken, 1'b0);
        step();
        drive(WR, 12'h305, 32'h101);
        #1;
        chk1("B_settle_stall", csr_stall, 1'b1);
        chk1("B_settle_blocks_irq", trap_taken, 1'b0);
        step();
        drive(WR, 12'h340, 32'h1);
        exc_pc = 32'h4000; exc_tval = 32'h77;
        #1;
        chk1("B_trap_taken", trap_taken, 1'b1);
        chk("B_trap_vector", trap_vector, 32'h11C);
        step();
        cmd = NONE;
        irq_timer = 1'b0;
        #1;
        chk1("B_no_retrap", trap_taken, 1'b0);
        chk1("B_mie_cleared", mstatus_mie, 1'b0);
        chk("B_epc_out", epc_out, 32'h4000);
        peek("B_mcause", 12'h342, 32'h8000_0007);
        peek("B_mstatus", 12'h300, 32'h1880);
        peek("B_mtval", 12'h343, 32'h0);
        peek("B_mscratch_kept", 12'h340, 32'h0000_BEFF);

        // Exception beats mret and irq_ext; then mret restores MIE
        drive(SET, 12'h300, 32'h8);
        step();
        cmd = NONE;
        step();
        exception = 1'b1; exc_cause = 4'd2; exc_pc = 32'h2003; exc_tval = 32'h55;
        mret = 1'b1; irq_ext = 1'b1;
        #1;
        chk1("C_trap_taken", trap_taken, 1'b1);
        chk("C_trap_vector", trap_vector, 32'h100);
        step();
        exception = 1'b0; mret = 1'b0; irq_ext = 1'b0;
        #1;
        chk("C_epc_out", epc_out, 32'h2000);
        chk1("C_mie_cleared", mstatus_mie, 1'b0);
        peek("C_mcause", 12'h342, 32'h2);
        peek("C_mtval", 12'h343, 32'h55);
        peek("C_mstatus", 12'h300, 32'h1880);
        mret = 1'b1;
        #1;
        chk1("C_mret_no_trap", trap_taken, 1'b0);
        step();
        mret = 1'b0;
        #1;
        chk1("C_mie_restored", mstatus_mie, 1'b1);
        peek("C_mstatus_after_mret", 12'h300, 32'h1888);

        // Counter carry, write-over-increment, no retire count on trap
        drive(WR, 12'hB80, 32'h0);
        step();
        drive(WR, 12'hB00, 32'hFFFF_FFFF);
        step();
        cmd = NONE;
        peek("D_mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        peek("D_mcycleh_written", 12'hB80, 32'h0);
        step();
        peek("D_mcycle_carry", 12'hB00, 32'h0);
        peek("D_mcycleh_carry", 12'hB80, 32'h1);
        drive(WR, 12'hB82, 32'h5);
        step();
        drive(WR, 12'hB02, 32'h100);
        retire = 1'b1;
        step();
        cmd = NONE;
        peek("D_minstret_write_wins", 12'hB02, 32'h100);
        peek("D_minstreth_kept", 12'hB82, 32'h5);
        step();
        peek("D_minstret_inc", 12'hB02, 32'h101);
        exception = 1'b1; exc_cause = 4'd0; exc_pc = 32'h3000; exc_tval = 32'h0;
        step();
        exception = 1'b0; retire = 1'b0;
        peek("D_minstret_trap_hold", 12'hB02, 32'h101);

        // Reset while in SETTLE
        drive(WR, 12'h304, 32'h0);
        step();
        cmd = NONE;
        #1;
        chk1("E_stall_pre_reset", csr_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("E_stall_reset", csr_stall, 1'b0);
        chk("E_trap_vector", trap_vector, 32'h100);
        chk("E_epc_out", epc_out, 32'h0);
        peek("E_mcycle", 12'hB00, 32'h0);
        peek("E_mcycleh", 12'hB80, 32'h0);
        peek("E_minstret", 12'hB02, 32'h0);
        peek("E_mtvec", 12'h305, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        peek("E_first_increment", 12'hB00, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/csr_file_m.md
CSR_FILE_M -- requirements
Module: csr_file_m

Interface
REQ-001 SHALL have parameter XLEN, 32, data/register width.
REQ-002 SHALL have parameter CNT_W, 64, mcycle/minstret width; XLEN < CNT_W <= 2*XLEN.
REQ-003 SHALL have parameter MTVEC_RST, 32'h0000_0100, mtvec reset value.
REQ-004 SHALL have parameter MISA_VAL, 32'h4000_0100, read-only misa value.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: cmd in 2 (0 NONE, 1 WRITE, 2 SET, 3 CLEAR); addr in 12 CSR address; wdata in XLEN; rdata out XLEN; illegal out 1.
REQ-007 SHALL have ports: exception in 1; exc_cause in 4; exc_pc in XLEN (current pc); exc_tval in XLEN; mret in 1; retire in 1.
REQ-008 SHALL have ports: irq_ext, irq_sw, irq_timer in 1 each, level-sensitive.
REQ-009 SHALL have ports: trap_taken out 1; trap_vector out XLEN; epc_out out XLEN; csr_stall out 1; mstatus_mie out 1.

Function
REQ-010 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, MPP bits12:11 read 2'b11, all else 0), misa 0x301 RO, mie 0x304 (MSIE3, MTIE7, MEIE11), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 RO, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14 RO reads 0.
REQ-011 SHALL drive rdata combinationally from addr every cycle; unimplemented addr reads 0.
REQ-012 SHALL compute new value: WRITE wdata, SET old|wdata, CLEAR old&~wdata; written value visible on rdata the next cycle.
REQ-013 SHALL treat SET/CLEAR with wdata==0 as read-only access (no write, no side effect).
REQ-014 SHALL assert illegal combinationally when cmd!=NONE and addr unimplemented, or a writing access targets a RO address; illegal accesses SHALL not modify state.
REQ-015 SHALL hold mepc[1:0] at 0 on every write path.
REQ-016 SHALL expose high counter halves as bits CNT_W-1:XLEN zero-extended to XLEN.
REQ-017 SHALL increment mcycle every cycle and minstret on retire when no trap is taken that cycle; both wrap from 2^CNT_W-1 to 0.
REQ-018 SHALL let a CSR write to a counter half override that cycle's increment of that counter; the other half keeps its value.
REQ-019 SHALL reflect mip = {MEIP=irq_ext, MTIP=irq_timer, MSIP=irq_sw} registered one cycle.
REQ-020 SHALL take an interrupt when mstatus.MIE=1, (mip & mie)!=0 and FSM is IDLE; priority MEI(11) > MSI(3) > MTI(7).
REQ-021 SHALL apply per-cycle priority: exception > interrupt > mret > CSR write; lower-priority actions that cycle are dropped (illegal still reported).
REQ-022 SHALL on trap: assert trap_taken same cycle (combinational); next edge mepc<=exc_pc, mcause<={interrupt bit XLEN-1, cause}, mtval<=exc_tval (0 for interrupt), MPIE<=MIE, MIE<=0.
REQ-023 SHALL drive trap_vector = {mtvec[XLEN-1:2],2'b00}, plus 4*cause when mtvec[1:0]==01 and trap is an interrupt; mtvec[1:0] values 1x SHALL be written as 00.
REQ-024 SHALL on mret: next edge MIE<=MPIE, MPIE<=1; epc_out always equals mepc.
REQ-025 SHALL have FSM IDLE/SETTLE: a successful write to mstatus or mie moves IDLE->SETTLE; SETTLE asserts csr_stall, blocks interrupts, returns to IDLE after one cycle.
REQ-026 SHALL let exceptions be taken in SETTLE; trap in SETTLE still returns to IDLE next cycle.
REQ-027 SHALL drive mstatus_mie = mstatus.MIE registered value.

Reset
REQ-028 SHALL on rst_n low asynchronously set: MIE=0, MPIE=0, mie=0, mip=0, mepc=0, mcause=0, mtval=0, mscratch=0, counters=0, mtvec=MTVEC_RST, FSM=IDLE.
REQ-029 SHALL hold outputs at reset: trap_taken=0, csr_stall=0, epc_out=0, mstatus_mie=0, trap_vector=MTVEC_RST; rdata per addr.
REQ-030 SHALL abandon any in-flight SETTLE or pending trap on reset mid-operation; first increment on first edge after rst_n rises.

Verification
REQ-031 SET 0x300 wdata 0x8 -> next cycle rdata 0x1808, csr_stall=1 one cycle, mstatus_mie=1.
REQ-032 mie=0x80, MIE=1, irq_timer=1 -> trap_taken after mip registers, mcause 0x8000_0007, vectored mtvec 0x101 gives trap_vector 0x11C, MIE=0, MPIE=1.
REQ-033 exception cause 2, exc_pc 0x2003, with mret and irq_ext same cycle -> exception only, mepc 0x2000, mcause 2; then mret -> MIE restored, MPIE=1.
REQ-034 WRITE mcycle 0xFFFF_FFFF, mcycleh 0 -> next cycle carry: mcycle 0, mcycleh 1; write minstret while retire=1 -> written value wins.
REQ-035 WRITE to 0xF14 and cmd SET at 0x7C0 -> illegal=1, no state change; SET 0xF14 wdata 0 -> illegal=0, rdata 0.
REQ-036 assert rst_n low during SETTLE with counters nonzero -> immediately csr_stall=0, counters 0, mtvec=MTVEC_RST.
